// File: rtl/usb4_lane_training_os_scheduler.sv
// usb4_lane_training_os_scheduler: sequences SLOS1/SLOS2/TS1/TS2 ordered-set offers for one USB4 lane during training
module usb4_lane_training_os_scheduler #(
    parameter int CNT_W        = 16,
    parameter int SLOS1_TX_MIN = 2,
    parameter int SLOS2_TX_MIN = 2,
    parameter int TS1_TX_MIN   = 16,
    parameter int TS2_TX_MIN   = 8,
    parameter int RX_MIN       = 2,
    parameter int TMO_W        = 20,
    parameter int TMO_CYC      = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             rx_slos1,
    input  logic             rx_slos2,
    input  logic             rx_ts1,
    input  logic             rx_ts2,
    output logic             os_valid,
    output logic [1:0]       os_type,
    input  logic             os_ready,
    output logic             done,
    output logic             fail,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] tx_slos1_cnt,
    output logic [CNT_W-1:0] tx_slos2_cnt,
    output logic [CNT_W-1:0] tx_ts1_cnt,
    output logic [CNT_W-1:0] tx_ts2_cnt,
    output logic [CNT_W-1:0] rx_slos1_cnt,
    output logic [CNT_W-1:0] rx_slos2_cnt,
    output logic [CNT_W-1:0] rx_ts1_cnt,
    output logic [CNT_W-1:0] rx_ts2_cnt
);
    typedef enum logic [2:0] {IDLE, SLOS1, SLOS2, TS1, TS2, DONE, FAIL} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t cur, nxt;
    logic [3:0][CNT_W-1:0] tx_cnt, rx_cnt;
    logic [3:0] rx_in;
    logic [TMO_W-1:0] tmo;
    logic [CNT_W:0] tx_min;
    logic active, accept, exit_ok, clr;

    assign active = (cur == SLOS1) || (cur == SLOS2) || (cur == TS1) || (cur == TS2);
    assign os_valid = active;
    assign os_type = active ? 2'(cur - 3'd1) : 2'd0;
    assign done = (cur == DONE);
    assign fail = (cur == FAIL);
    assign state = cur;
    assign accept = os_valid & os_ready;
    assign rx_in = {rx_ts2, rx_ts1, rx_slos2, rx_slos1};
    assign clr = start & ~abort & ~active;
    assign {tx_ts2_cnt, tx_ts1_cnt, tx_slos2_cnt, tx_slos1_cnt} = tx_cnt;
    assign {rx_ts2_cnt, rx_ts1_cnt, rx_slos2_cnt, rx_slos1_cnt} = rx_cnt;

    // threshold of the phase currently being offered
    always_comb begin
        tx_min = (os_type == 2'd0) ? (CNT_W+1)'(SLOS1_TX_MIN) :
                 (os_type == 2'd1) ? (CNT_W+1)'(SLOS2_TX_MIN) :
                 (os_type == 2'd2) ? (CNT_W+1)'(TS1_TX_MIN) : (CNT_W+1)'(TS2_TX_MIN);
        exit_ok = accept && (({1'b0, tx_cnt[os_type]} + 1'b1) >= tx_min) &&
                  (rx_cnt[os_type] >= CNT_W'(RX_MIN));
    end

    // next-state: abort dominates, exit beats timeout, start only from idle/done/fail
    always_comb begin
        nxt = cur;
        if (abort)
            nxt = IDLE;
        else if (!active)
            nxt = start ? SLOS1 : cur;
        else if (exit_ok)
            nxt = state_t'(cur + 3'd1);
        else if (tmo == TMO_LAST)
            nxt = FAIL;
    end

    // state register and per-phase timeout, restarted on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= IDLE;
            tmo <= '0;
        end else begin
            cur <= nxt;
            tmo <= (nxt != cur) ? '0 : active ? tmo + 1'b1 : '0;
        end
    end

    // saturating sent/received counters; cleared by a new session, frozen by abort
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || clr) begin
                tx_cnt[i] <= '0;
                rx_cnt[i] <= '0;
            end else if (!abort) begin
                if (accept && os_type == 2'(i) && tx_cnt[i] != CNT_MAX)
                    tx_cnt[i] <= tx_cnt[i] + 1'b1;
                if (cur != IDLE && rx_in[i] && rx_cnt[i] != CNT_MAX)
                    rx_cnt[i] <= rx_cnt[i] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_usb4_lane_training_os_scheduler.sv
// tb_usb4_lane_training_os_scheduler: directed checks of phase sequencing, backpressure, timeout, abort and reset
module tb_usb4_lane_training_os_scheduler;
    logic clk = 0, rst = 1, start = 0, abort = 0, os_ready = 0;
    logic rx_slos1 = 0, rx_slos2 = 0, rx_ts1 = 0, rx_ts2 = 0;
    logic os_valid, done, fail;
    logic [1:0] os_type;
    logic [2:0] state;
    logic [15:0] tx_slos1_cnt, tx_slos2_cnt, tx_ts1_cnt, tx_ts2_cnt;
    logic [15:0] rx_slos1_cnt, rx_slos2_cnt, rx_ts1_cnt, rx_ts2_cnt;
    int n_chk = 0, n_fail = 0, k;

    usb4_lane_training_os_scheduler #(.TMO_CYC(100)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rx_slos1(rx_slos1), .rx_slos2(rx_slos2), .rx_ts1(rx_ts1), .rx_ts2(rx_ts2),
        .os_valid(os_valid), .os_type(os_type), .os_ready(os_ready),
        .done(done), .fail(fail), .state(state),
        .tx_slos1_cnt(tx_slos1_cnt), .tx_slos2_cnt(tx_slos2_cnt),
        .tx_ts1_cnt(tx_ts1_cnt), .tx_ts2_cnt(tx_ts2_cnt),
        .rx_slos1_cnt(rx_slos1_cnt), .rx_slos2_cnt(rx_slos2_cnt),
        .rx_ts1_cnt(rx_ts1_cnt), .rx_ts2_cnt(rx_ts2_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rx(input logic [3:0] m, input int n);
        {rx_ts2, rx_ts1, rx_slos2, rx_slos1} = m;
        repeat (n) tick();
        {rx_ts2, rx_ts1, rx_slos2, rx_slos1} = 4'b0;
    endtask

    task automatic go();
        start = 1;
        tick();
        start = 0;
    endtask

    function automatic logic [1:0] exp_type(input int i);
        return (i < 2) ? 2'd0 : (i < 4) ? 2'd1 : (i < 20) ? 2'd2 : 2'd3;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        chk("rst_state", state, 0);
        chk("rst_valid", os_valid, 0);
        chk("rst_type", os_type, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        rst = 0;
        tick();
        chk("idle_hold", state, 0);

        // nominal: rx credit first, then ready held high
        go();
        chk("entry_slos1", state, 1);
        chk("entry_valid", os_valid, 1);
        pulse_rx(4'hf, 2);
        os_ready = 1;
        for (int i = 0; i < 28; i++) begin
            chk("nom_valid", os_valid, 1);
            chk("nom_type", os_type, exp_type(i));
            tick();
        end
        chk("nom_done", done, 1);
        chk("nom_state", state, 5);
        chk("nom_valid_off", os_valid, 0);
        chk("nom_tx_slos1", tx_slos1_cnt, 2);
        chk("nom_tx_slos2", tx_slos2_cnt, 2);
        chk("nom_tx_ts1", tx_ts1_cnt, 16);
        chk("nom_tx_ts2", tx_ts2_cnt, 8);
        chk("nom_rx_ts2", rx_ts2_cnt, 2);

        // backpressure with ready pattern 1,0,0,1
        os_ready = 0;
        go();
        chk("bp_clr_done", done, 0);
        chk("bp_clr_tx", tx_ts1_cnt, 0);
        chk("bp_clr_rx", rx_slos1_cnt, 0);
        pulse_rx(4'hf, 2);
        k = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            os_ready = (c % 4 == 0) || (c % 4 == 3);
            chk("bp_type", os_type, exp_type(k));
            if (c == 1 || c == 2) chk("bp_tx_hold", tx_slos1_cnt, 1);
            if (os_ready) k++;
            tick();
        end
        os_ready = 0;
        chk("bp_done", done, 1);
        chk("bp_tx_slos1", tx_slos1_cnt, 2);
        chk("bp_tx_ts1", tx_ts1_cnt, 16);
        chk("bp_tx_ts2", tx_ts2_cnt, 8);

        // partner slow in TS1
        go();
        pulse_rx(4'b1011, 2);
        os_ready = 1;
        repeat (4) tick();
        chk("slow_in_ts1", state, 3);
        repeat (40) tick();
        chk("slow_stay_ts1", state, 3);
        chk("slow_tx40", tx_ts1_cnt, 40);
        os_ready = 0;
        pulse_rx(4'b0100, 2);
        chk("slow_no_accept", state, 3);
        os_ready = 1;
        tick();
        os_ready = 0;
        chk("slow_exit", state, 4);
        chk("slow_tx41", tx_ts1_cnt, 41);

        // start inside TS2 is ignored
        start = 1;
        tick();
        start = 0;
        chk("ts2_start_ign", state, 4);
        chk("ts2_start_cnt", tx_ts1_cnt, 41);

        // reset mid-TS2 with an offer outstanding
        chk("pre_rst_valid", os_valid, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("mrst_state", state, 0);
        chk("mrst_valid", os_valid, 0);
        chk("mrst_type", os_type, 0);
        chk("mrst_tx_ts1", tx_ts1_cnt, 0);
        chk("mrst_rx_ts2", rx_ts2_cnt, 0);

        // abort and start together in TS1
        go();
        pulse_rx(4'hf, 2);
        os_ready = 1;
        repeat (4) tick();
        os_ready = 0;
        chk("ab_in_ts1", state, 3);
        abort = 1;
        start = 1;
        tick();
        abort = 0;
        start = 0;
        chk("ab_state", state, 0);
        chk("ab_valid", os_valid, 0);
        chk("ab_tx_slos2", tx_slos2_cnt, 2);
        chk("ab_rx_ts1", rx_ts1_cnt, 2);
        tick();
        chk("ab_stay_idle", state, 0);

        // timeout: no rx credit, offers accepted every cycle
        go();
        chk("tmo_entry", state, 1);
        os_ready = 1;
        repeat (99) tick();
        chk("tmo_before", state, 1);
        tick();
        os_ready = 0;
        chk("tmo_state", state, 6);
        chk("tmo_fail", fail, 1);
        chk("tmo_valid", os_valid, 0);
        chk("tmo_tx", tx_slos1_cnt, 100);
        go();
        chk("tmo_restart", state, 1);
        chk("tmo_fail_clr", fail, 0);
        chk("tmo_cnt_clr", tx_slos1_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/usb4_lane_training_os_scheduler.md
Name: usb4_lane_training_os_scheduler

Overview:
- Sequences ordered-set (OS) transmission for one USB4 lane during link training: SLOS1, then SLOS2, then TS1, then TS2.
- Offers one OS type at a time to the lane OS transmitter through a valid/ready handshake.
- Counts sent and received OSs per type and advances phases on count thresholds.
- Sits between the LTSSM (start/abort, done/fail) and the serdes-side OS generator. Its counters mirror the per-type sent/received counts exposed on the lane debug interface.

Parameters:
- CNT_W, 16, width of every sent/received counter.
- SLOS1_TX_MIN, 2, SLOS1 sent before leaving SLOS1.
- SLOS2_TX_MIN, 2, SLOS2 sent before leaving SLOS2.
- TS1_TX_MIN, 16, TS1 sent before leaving TS1.
- TS2_TX_MIN, 8, TS2 sent before DONE.
- RX_MIN, 2, matching OSs received from the partner before leaving a phase.
- TMO_W, 20, timeout counter width.
- TMO_CYC, 1000000, cycles allowed per phase before FAIL.

Ports:
- clk  in  1  Single clock.
- rst  in  1  Synchronous, active-high reset.
- start  in  1  Pulse; begins a training session from IDLE, DONE or FAIL.
- abort  in  1  Pulse; returns to IDLE from any state.
- rx_slos1  in  1  One-cycle pulse per SLOS1 received.
- rx_slos2  in  1  One-cycle pulse per SLOS2 received.
- rx_ts1  in  1  One-cycle pulse per TS1 received.
- rx_ts2  in  1  One-cycle pulse per TS2 received.
- os_valid  out  1  An OS of os_type is offered.
- os_type  out  2  0=SLOS1, 1=SLOS2, 2=TS1, 3=TS2.
- os_ready  in  1  Transmitter accepts the OS this cycle.
- done  out  1  Training sequence completed; held high.
- fail  out  1  Phase timeout occurred; held high.
- state  out  3  0=IDLE, 1=SLOS1, 2=SLOS2, 3=TS1, 4=TS2, 5=DONE, 6=FAIL.
- tx_slos1_cnt, tx_slos2_cnt, tx_ts1_cnt, tx_ts2_cnt  out  CNT_W each  Accepted OSs per type.
- rx_slos1_cnt, rx_slos2_cnt, rx_ts1_cnt, rx_ts2_cnt  out  CNT_W each  Received OSs per type.

Behaviour:
- Reset: state=IDLE; os_valid=0; os_type=0; done=0; fail=0; all counters=0; timeout counter=0.
- Accept: an accept is os_valid & os_ready in the same cycle. The matching tx counter increments on the next edge.
- Rx counting: each rx_* pulse increments its own counter on the next edge, in every state except IDLE. Pulses in IDLE are ignored.
- Counter rules: all counters saturate at 2^CNT_W-1. All counters clear on the start edge.
- Valid per state: os_valid=1 in SLOS1/SLOS2/TS1/TS2, driven from the registered state, so it is high the cycle after entry. os_valid=0 in IDLE/DONE/FAIL.
- os_type stability: os_type equals the phase type and never changes while os_valid=1 unless an accept occurs in that cycle.
- IDLE: on start, go to SLOS1.
- Phase exit condition for phase P, with type X and threshold X_TX_MIN: accept of X this cycle AND (tx_X_cnt+1) >= X_TX_MIN AND rx_X_cnt >= RX_MIN. Rx counts are registered values; a same-cycle rx pulse does not count toward this cycle's decision.
- Phase transitions: SLOS1->SLOS2->TS1->TS2->DONE, each on its exit condition. Transitions happen only on accept cycles, so the next offered OS is the new type.
- Timeout: clears on every state entry and increments each cycle in an active phase. When it reaches TMO_CYC-1 with no exit that cycle, go to FAIL. If exit and timeout coincide, exit wins.
- Withdrawal: os_valid may drop without an accept only on entry to FAIL, on abort, or on rst.
- DONE/FAIL: done=1 in DONE and fail=1 in FAIL, held until leaving. start re-enters SLOS1 and clears done/fail and all counters.
- start in SLOS1..TS2 is ignored.
- abort from any state: go to IDLE next cycle, os_valid=0, done=fail=0. Counters hold their values.
- abort and start in the same cycle: abort wins.
- rst mid-operation: full reset values next cycle. Any in-flight offer is dropped.

Test Plan:
- Nominal run: os_ready tied 1, rx_* pulsed early with 2 each; start -> os_type sequence 0,0,1,1,2×16,3×8; done=1 one cycle after the 28th accept; tx counts 2/2/16/8.
- Backpressure: os_ready toggles 1,0,0,1 -> os_type constant while valid; each tx counter increments only on accept cycles; the final tx counts are unchanged.
- Partner slow: rx_ts1 arrives only after 40 TS1 sent -> stays in TS1 (tx_ts1_cnt=40+), exits on the first accept after rx_ts1_cnt reaches 2.
- Timeout: TMO_CYC=100, no rx pulses -> state=FAIL and fail=1 exactly 100 cycles after SLOS1 entry, os_valid=0; a later start -> SLOS1 with all counters 0.
- Abort and start together in TS1 -> IDLE, os_valid=0, counters retained; start alone in TS2 -> ignored.
- rst asserted mid-TS2 with os_valid=1 -> next cycle every output at its reset value.
